// File: rtl/nf10_id_reader_defs.sv
// nf10_id_reader_defs: shared state encoding, AXI read-response codes and
// buffer geometry used by the nf10_id_reader block and its buffer.
package nf10_id_reader_defs;

    // Read master sequencing: wait for start, present address, collect data.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } readerState_e;

    // AXI RRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // err_code reported when the slave never answers; it shares DECERR's code
    // because a missing response is as fatal as an undecodable address.
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Local buffer is always 16 words of 32 bits, regardless of run length.
    localparam int BUF_DEPTH = 16;
    localparam int WORD_W    = 32;

    // Byte offset of a 32-bit word inside the target's register map.
    function automatic logic [5:0] wordOffset(input logic [3:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/nf10_id_reader_buf.sv
// nf10_id_reader_buf: 16 x 32 identifier store with one write port and one
// registered read port. The array itself has no reset so that identifiers
// fetched before a reset can still be read afterwards.
module nf10_id_reader_buf
    import nf10_id_reader_defs::*;
#(
    parameter int NUM_WORDS = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wrEn_i,
    input  logic [3:0]        wrIdx_i,
    input  logic [WORD_W-1:0] wrData_i,
    input  logic [3:0]        rdIdx_i,
    output logic [WORD_W-1:0] rdData_o
);

    logic [WORD_W-1:0] mem_q [BUF_DEPTH];
    logic [WORD_W-1:0] rdData_q;
    logic              rdInRange;

    assign rdInRange = ({1'b0, rdIdx_i} < 5'(NUM_WORDS));

    // Capture accepted read data; intentionally no reset on the storage.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem_q[wrIdx_i] <= wrData_i;
        end
    end

    // Registered read port; indices past the run length read as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdData_q <= '0;
        end else begin
            rdData_q <= rdInRange ? mem_q[rdIdx_i] : '0;
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/nf10_id_reader.sv
// nf10_id_reader: AXI4-Lite read-only master that fetches C_NUM_WORDS
// consecutive 32-bit identifier words starting at C_TARGET_BASEADDR into a
// local buffer, one outstanding read at a time, and reports done or error.
// Optional feature: define ID_READER_TIMEOUT_EN to abort a read whose data
// does not arrive within C_TIMEOUT_CYCLES cycles (err_code 2'b11).
module nf10_id_reader
    import nf10_id_reader_defs::*;
#(
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASEADDR  = '0,
    parameter int                            C_NUM_WORDS        = 16,
    parameter int                            C_TIMEOUT_CYCLES   = 256
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [3:0]                    err_index,
    output logic [1:0]                    err_code,
    input  logic [3:0]                    buf_addr,
    output logic [WORD_W-1:0]             buf_data,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    output logic [2:0]                    M_AXI_ARPROT,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    // Reject configurations the buffer and datapath cannot represent.
    if (C_M_AXI_DATA_WIDTH != 32 || C_NUM_WORDS < 1 || C_NUM_WORDS > 16 ||
        C_TIMEOUT_CYCLES < 1) begin : g_paramCheck
        $error("nf10_id_reader: unsupported parameter combination");
    end

    readerState_e                  state_q;
    logic                          arvalid_q;
    logic                          rready_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          error_q;
    logic [3:0]                    idx_q;
    logic [3:0]                    errIndex_q;
    logic [1:0]                    errCode_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q;

    logic [3:0]                    idxNext_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddrNext_d;
    logic                          lastWord;
    logic                          bufWe;

`ifdef ID_READER_TIMEOUT_EN
    logic [31:0]                   toCnt_q;
`endif

    assign lastWord = (idx_q == 4'(C_NUM_WORDS - 1));
    assign bufWe    = (state_q == ST_DATA) && M_AXI_RVALID && (M_AXI_RRESP == RESP_OKAY);

    // Address of the following word, computed at full width so it wraps naturally.
    always_comb begin
        idxNext_d    = idx_q + 4'd1;
        araddrNext_d = C_TARGET_BASEADDR + C_M_AXI_ADDR_WIDTH'(wordOffset(idxNext_d));
    end

    // Read sequencer with all handshake and status outputs registered.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q    <= ST_IDLE;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            idx_q      <= '0;
            errIndex_q <= '0;
            errCode_q  <= '0;
            araddr_q   <= C_TARGET_BASEADDR;
`ifdef ID_READER_TIMEOUT_EN
            toCnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                        idx_q     <= '0;
                        araddr_q  <= C_TARGET_BASEADDR;
                        arvalid_q <= 1'b1;
                        rready_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_DATA;
`ifdef ID_READER_TIMEOUT_EN
                        toCnt_q   <= '0;
`endif
                    end
                end
                ST_DATA: begin
                    if (M_AXI_RVALID) begin
                        if (M_AXI_RRESP != RESP_OKAY) begin
                            error_q    <= 1'b1;
                            errIndex_q <= idx_q;
                            errCode_q  <= M_AXI_RRESP;
                            busy_q     <= 1'b0;
                            state_q    <= ST_IDLE;
                        end else if (lastWord) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q     <= idxNext_d;
                            araddr_q  <= araddrNext_d;
                            arvalid_q <= 1'b1;
                            rready_q  <= 1'b0;
                            state_q   <= ST_ADDR;
                        end
`ifdef ID_READER_TIMEOUT_EN
                    end else if (toCnt_q == 32'(C_TIMEOUT_CYCLES - 1)) begin
                        error_q    <= 1'b1;
                        errIndex_q <= idx_q;
                        errCode_q  <= ERR_TIMEOUT;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        toCnt_q <= toCnt_q + 32'd1;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    nf10_id_reader_buf #(
        .NUM_WORDS (C_NUM_WORDS)
    ) u_buf (
        .clk_i    (M_AXI_ACLK),
        .rst_ni   (M_AXI_ARESETN),
        .wrEn_i   (bufWe),
        .wrIdx_i  (idx_q),
        .wrData_i (M_AXI_RDATA[WORD_W-1:0]),
        .rdIdx_i  (buf_addr),
        .rdData_o (buf_data)
    );

    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = rready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_index     = errIndex_q;
    assign err_code      = errCode_q;

endmodule

// File: tb/tb_nf10_id_reader.sv
// tb_nf10_id_reader: randomized bench for nf10_id_reader with a behavioural
// AXI-Lite slave and a word-level reference of the expected buffer contents.
// The timeout scenario is compiled in when ID_READER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_nf10_id_reader;

    localparam int          NW   = 16;
    localparam int          TO   = 16;
    localparam logic [31:0] BASE = 32'hFFFF_FFE0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [3:0]  errIndex;
    logic [1:0]  errCode;
    logic [3:0]  bufAddr = '0;
    logic [31:0] bufData;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [2:0]  arprot;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;

    int checks;
    int failures;

    // slave configuration, set by the scenarios
    int          arStallMax;
    int          rStallMax;
    int          errWord;
    int          withholdWord;
    logic [1:0]  errResp;
    logic [31:0] slaveMem [16];

    // observations from the slave
    logic [31:0] arLog [$];
    int          stableViol;

    // reference model of the local buffer
    logic [31:0] refBuf [16];

    // slave internal state
    logic        arFire = 1'b0;
    logic        rFire = 1'b0;
    logic        pendR = 1'b0;
    logic        arStalling = 1'b0;
    int          arWait;
    int          rWait;
    logic [31:0] heldAddr;
    logic [3:0]  pendIdx;

    always #5 clk = ~clk;

    nf10_id_reader #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (32),
        .C_TARGET_BASEADDR  (BASE),
        .C_NUM_WORDS        (NW),
        .C_TIMEOUT_CYCLES   (TO)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_index     (errIndex),
        .err_code      (errCode),
        .buf_addr      (bufAddr),
        .buf_data      (bufData),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    // Behavioural AXI-Lite slave; decides at each falling edge what happens
    // at the following rising edge, so it never races the DUT registers.
    always @(negedge clk) begin
        if (!rst_n) begin
            arready    = 1'b0;
            rvalid     = 1'b0;
            pendR      = 1'b0;
            arFire     = 1'b0;
            rFire      = 1'b0;
            arStalling = 1'b0;
        end else begin
            if (rFire) begin
                pendR = 1'b0;
                rFire = 1'b0;
            end
            if (arFire) begin
                pendR   = 1'b1;
                arFire  = 1'b0;
                pendIdx = 4'((heldAddr - BASE) >> 2);
                rWait   = int'($urandom_range(rStallMax, 0));
            end
            arready = 1'b0;
            if (arStalling && (!arvalid || araddr !== heldAddr)) stableViol++;
            if (arvalid && !pendR) begin
                if (!arStalling) begin
                    arStalling = 1'b1;
                    heldAddr   = araddr;
                    arWait     = int'($urandom_range(arStallMax, 0));
                end
                if (arWait == 0) begin
                    arready    = 1'b1;
                    arFire     = 1'b1;
                    arStalling = 1'b0;
                    arLog.push_back(heldAddr);
                end else begin
                    arWait--;
                end
            end
            rvalid = 1'b0;
            if (pendR && int'(pendIdx) != withholdWord) begin
                if (rWait > 0) begin
                    rWait--;
                end else begin
                    rvalid = 1'b1;
                    rdata  = slaveMem[pendIdx];
                    rresp  = (int'(pendIdx) == errWord) ? errResp : 2'b00;
                    if (rready) rFire = 1'b1;
                end
            end
        end
    end

    // Runaway guard in case the DUT or a scenario never settles.
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitEnd(input int budget, output int cycles, output logic timedOut);
        cycles   = 0;
        timedOut = 1'b1;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (done || error) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic readBuf(input int a, output logic [31:0] d);
        bufAddr = 4'(a);
        @(negedge clk);
        d = bufData;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({arvalid, rready, busy, done, error} !== 5'b01000) begin
            failures++;
            $display("FAIL reset_flags got arvalid,rready,busy,done,error=%b want=01000",
                     {arvalid, rready, busy, done, error});
        end
        checks++;
        if ({errIndex, errCode} !== 6'd0) begin
            failures++;
            $display("FAIL reset_err got idx=%0d code=%0d want 0/0", errIndex, errCode);
        end
        checks++;
        if (araddr !== BASE || arprot !== 3'b000) begin
            failures++;
            $display("FAIL reset_araddr got=%h prot=%b want=%h/000", araddr, arprot, BASE);
        end
        checks++;
        if (bufData !== 32'd0) begin
            failures++;
            $display("FAIL reset_bufdata got=%h want=0", bufData);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        int          cyc;
        logic        to;
        int          bad;
        logic [31:0] d;
        arStallMax = 0; rStallMax = 0; errWord = -1; withholdWord = -1;
        for (int i = 0; i < 16; i++) slaveMem[i] = 32'hA500_0000 + 32'(i);
        arLog.delete();
        pulseStart();
        checks++;
        if (busy !== 1'b1 || arvalid !== 1'b1 || araddr !== BASE) begin
            failures++;
            $display("FAIL zw_first_ar got busy=%b arvalid=%b araddr=%h want 1/1/%h",
                     busy, arvalid, araddr, BASE);
        end
        waitEnd(2000, cyc, to);
        checks++;
        if (to || cyc != 2 * NW) begin
            failures++;
            $display("FAIL zw_latency got=%0d cycles (timeout=%b) want=%0d", cyc, to, 2 * NW);
        end
        checks++;
        if ({done, error, busy} !== 3'b100) begin
            failures++;
            $display("FAIL zw_status got done,error,busy=%b want=100", {done, error, busy});
        end
        bad = 0;
        foreach (arLog[i]) if (arLog[i] !== BASE + 32'(4 * i)) bad++;
        checks++;
        if (arLog.size() != NW || bad != 0) begin
            failures++;
            $display("FAIL zw_araddr got count=%0d bad=%0d want count=%0d bad=0", arLog.size(), bad, NW);
        end
        for (int i = 0; i < NW; i++) refBuf[i] = slaveMem[i];
        readBuf(5, d);
        checks++;
        if (d !== 32'hA500_0005) begin
            failures++;
            $display("FAIL zw_word5 got=%h want=a5000005", d);
        end
        for (int a = 0; a < 16; a++) begin
            readBuf(a, d);
            checks++;
            if (d !== ((a < NW) ? refBuf[a] : 32'd0)) begin
                failures++;
                $display("FAIL zw_buf[%0d] got=%h want=%h", a, d, (a < NW) ? refBuf[a] : 32'd0);
            end
        end
    endtask

    task automatic test_random_stalls();
        int          cyc;
        logic        to;
        int          bad;
        logic [31:0] d;
        for (int run = 0; run < 3; run++) begin
            arStallMax = 7; rStallMax = 7; errWord = -1; withholdWord = -1;
            for (int i = 0; i < 16; i++)
                slaveMem[i] = (run == 0) ? 32'hA500_0000 + 32'(i) : $urandom;
            arLog.delete();
            stableViol = 0;
            pulseStart();
            waitEnd(4000, cyc, to);
            checks++;
            if (to || {done, error, busy} !== 3'b100) begin
                failures++;
                $display("FAIL stall%0d_status got done,error,busy=%b timeout=%b want=100",
                         run, {done, error, busy}, to);
            end
            checks++;
            if (stableViol != 0) begin
                failures++;
                $display("FAIL stall%0d_ar_stable got=%0d violations want=0", run, stableViol);
            end
            bad = 0;
            foreach (arLog[i]) if (arLog[i] !== BASE + 32'(4 * i)) bad++;
            checks++;
            if (arLog.size() != NW || bad != 0) begin
                failures++;
                $display("FAIL stall%0d_araddr got count=%0d bad=%0d want count=%0d bad=0",
                         run, arLog.size(), bad, NW);
            end
            for (int i = 0; i < NW; i++) refBuf[i] = slaveMem[i];
            for (int a = 0; a < 16; a++) begin
                readBuf(a, d);
                checks++;
                if (d !== ((a < NW) ? refBuf[a] : 32'd0)) begin
                    failures++;
                    $display("FAIL stall%0d_buf[%0d] got=%h want=%h", run, a, d,
                             (a < NW) ? refBuf[a] : 32'd0);
                end
            end
        end
    endtask

    task automatic test_bad_response();
        int          cyc;
        logic        to;
        logic [31:0] d;
        for (int run = 0; run < 3; run++) begin
            arStallMax = 3; rStallMax = 3; withholdWord = -1;
            errWord = (run == 0) ? 3 : int'($urandom_range(NW - 1, 0));
            errResp = (run == 0) ? 2'b10 : 2'($urandom_range(3, 1));
            for (int i = 0; i < 16; i++) slaveMem[i] = $urandom;
            arLog.delete();
            pulseStart();
            checks++;
            if (done !== 1'b0 || error !== 1'b0) begin
                failures++;
                $display("FAIL err%0d_start_clears got done=%b error=%b want 0/0", run, done, error);
            end
            waitEnd(2000, cyc, to);
            checks++;
            if (to || {done, error, busy} !== 3'b010) begin
                failures++;
                $display("FAIL err%0d_status got done,error,busy=%b timeout=%b want=010",
                         run, {done, error, busy}, to);
            end
            checks++;
            if (errIndex !== 4'(errWord) || errCode !== errResp) begin
                failures++;
                $display("FAIL err%0d_info got idx=%0d code=%b want idx=%0d code=%b",
                         run, errIndex, errCode, errWord, errResp);
            end
            repeat (10) @(negedge clk);
            checks++;
            if (arLog.size() != errWord + 1 || arvalid !== 1'b0) begin
                failures++;
                $display("FAIL err%0d_no_more_ar got reads=%0d arvalid=%b want reads=%0d arvalid=0",
                         run, arLog.size(), arvalid, errWord + 1);
            end
            for (int i = 0; i < errWord; i++) refBuf[i] = slaveMem[i];
            for (int a = 0; a < 16; a++) begin
                readBuf(a, d);
                checks++;
                if (d !== ((a < NW) ? refBuf[a] : 32'd0)) begin
                    failures++;
                    $display("FAIL err%0d_buf[%0d] got=%h want=%h", run, a, d,
                             (a < NW) ? refBuf[a] : 32'd0);
                end
            end
        end
        errWord = -1;
    endtask

    task automatic test_midrun_start_and_reset();
        int          cyc;
        int          w;
        int          bad;
        logic        to;
        logic [31:0] d;
        arStallMax = 2; rStallMax = 2; errWord = -1; withholdWord = 5;
        for (int i = 0; i < 16; i++) slaveMem[i] = $urandom;
        arLog.delete();
        pulseStart();
        w = 0;
        while (arLog.size() < 2 && w < 500) begin
            @(negedge clk);
            w++;
        end
        pulseStart();
        w = 0;
        while (arLog.size() < 6 && w < 500) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        bad = 0;
        foreach (arLog[i]) if (arLog[i] !== BASE + 32'(4 * i)) bad++;
        checks++;
        if (arLog.size() != 6 || bad != 0) begin
            failures++;
            $display("FAIL mid_start_ignored got reads=%0d bad=%0d want reads=6 bad=0", arLog.size(), bad);
        end
        checks++;
        if (busy !== 1'b1 || rready !== 1'b1 || arvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_in_data got busy=%b rready=%b arvalid=%b want 1/1/0", busy, rready, arvalid);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({arvalid, rready, busy, done, error} !== 5'b01000 || araddr !== BASE) begin
            failures++;
            $display("FAIL mid_async_reset got flags=%b araddr=%h want flags=01000 araddr=%h",
                     {arvalid, rready, busy, done, error}, araddr, BASE);
        end
        checks++;
        if ({errIndex, errCode} !== 6'd0 || bufData !== 32'd0) begin
            failures++;
            $display("FAIL mid_async_reset_err got idx=%0d code=%0d buf=%h want 0/0/0",
                     errIndex, errCode, bufData);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) refBuf[i] = slaveMem[i];
        for (int a = 0; a < 16; a++) begin
            readBuf(a, d);
            checks++;
            if (d !== ((a < NW) ? refBuf[a] : 32'd0)) begin
                failures++;
                $display("FAIL mid_buf_survives[%0d] got=%h want=%h", a, d, (a < NW) ? refBuf[a] : 32'd0);
            end
        end
        withholdWord = -1; arStallMax = 1; rStallMax = 1;
        for (int i = 0; i < 16; i++) slaveMem[i] = $urandom;
        arLog.delete();
        pulseStart();
        waitEnd(2000, cyc, to);
        checks++;
        if (to || {done, error, busy} !== 3'b100 || arLog.size() != NW) begin
            failures++;
            $display("FAIL mid_rerun got done,error,busy=%b reads=%0d timeout=%b want=100 reads=%0d",
                     {done, error, busy}, arLog.size(), to, NW);
        end
        for (int i = 0; i < NW; i++) refBuf[i] = slaveMem[i];
        for (int a = 0; a < 16; a++) begin
            readBuf(a, d);
            checks++;
            if (d !== ((a < NW) ? refBuf[a] : 32'd0)) begin
                failures++;
                $display("FAIL mid_rerun_buf[%0d] got=%h want=%h", a, d, (a < NW) ? refBuf[a] : 32'd0);
            end
        end
    endtask

`ifdef ID_READER_TIMEOUT_EN
    task automatic test_timeout();
        int          cyc;
        int          w;
        logic        to;
        logic        seen;
        logic [31:0] d;
        arStallMax = 0; rStallMax = 0; errWord = -1; withholdWord = 0;
        for (int i = 0; i < 16; i++) slaveMem[i] = $urandom;
        arLog.delete();
        pulseStart();
        waitEnd(500, cyc, to);
        checks++;
        if (to || {done, error, busy} !== 3'b010 || errCode !== 2'b11 || errIndex !== 4'd0) begin
            failures++;
            $display("FAIL to_status got done,error,busy=%b code=%b idx=%0d want 010 code=11 idx=0",
                     {done, error, busy}, errCode, errIndex);
        end
        checks++;
        if (cyc != TO + 1) begin
            failures++;
            $display("FAIL to_latency got=%0d cycles want=%0d", cyc, TO + 1);
        end
        withholdWord = -1;
        seen = 1'b0;
        w = 0;
        while (!seen && w < 20) begin
            @(negedge clk);
            w++;
            if (rvalid && rready) seen = 1'b1;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!seen || busy !== 1'b0 || error !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL to_late_resp got accepted=%b busy=%b error=%b done=%b want 1/0/1/0",
                     seen, busy, error, done);
        end
        readBuf(0, d);
        checks++;
        if (d !== refBuf[0]) begin
            failures++;
            $display("FAIL to_word0_kept got=%h want=%h", d, refBuf[0]);
        end
        arLog.delete();
        pulseStart();
        waitEnd(2000, cyc, to);
        checks++;
        if (to || {done, error, busy} !== 3'b100 || cyc != 2 * NW) begin
            failures++;
            $display("FAIL to_rerun got done,error,busy=%b cycles=%0d want=100 cycles=%0d",
                     {done, error, busy}, cyc, 2 * NW);
        end
        for (int i = 0; i < NW; i++) refBuf[i] = slaveMem[i];
        for (int a = 0; a < 16; a++) begin
            readBuf(a, d);
            checks++;
            if (d !== ((a < NW) ? refBuf[a] : 32'd0)) begin
                failures++;
                $display("FAIL to_rerun_buf[%0d] got=%h want=%h", a, d, (a < NW) ? refBuf[a] : 32'd0);
            end
        end
    endtask
`endif

    // Scenario sequence followed by the single summary line.
    initial begin
        checks = 0; failures = 0;
        arStallMax = 0; rStallMax = 0; errWord = -1; withholdWord = -1;
        errResp = 2'b00; stableViol = 0;
        $display("[TB] nf10_id_reader bench starting");
        test_reset();
        test_zero_wait();
        test_random_stalls();
        test_bad_response();
        test_midrun_start_and_reset();
`ifdef ID_READER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
